regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file for the RISC-V core: NRD read ports,
//  NWR write ports and a per-register busy scoreboard for in-flight writers.
//  Sits between decode/issue (reads, busy checks, allocation) and write-back (commits).
//  Successor to the single-write/dual-read file; adds multiple write ports, a
//  configurable depth, busy tracking and an optional same-cycle write->read bypass.
// PARAMETERS
//  XLEN    64  data width in bits (32 or 64)
//  NREGS   32  architectural registers; power of two, 2..64; AW = $clog2(NREGS)
//  NRD     2   read ports, 1..4
//  NWR     2   write ports, 1..4; higher index has priority on address conflict
//  ZERO_R0 1   1: register 0 reads 0, ignores writes, never busy; 0: ordinary register
// PORTS
//  clk        in   1             rising-edge clock
//  resetn     in   1             asynchronous active-low reset
//  we         in   NWR           per-port write enable
//  waddr      in   NWR x AW      per-port write address
//  wdata      in   NWR x XLEN    per-port write data
//  raddr      in   NRD x AW      per-port read address
//  rdata      out  NRD x XLEN    per-port read data (combinational)
//  rbusy      out  NRD           busy bit of raddr[i] (combinational)
//  alloc      in   1             mark alloc_rd busy (issue of an instruction with rd)
//  alloc_rd   in   AW            register being allocated
//  busy_vec   out  NREGS         full scoreboard, for debug/stall logic
// BEHAVIOUR
//  Reset: all registers <= 0, all busy bits <= 0, asynchronously on resetn low.
//   Reset mid-operation discards all pending writes and allocations; after release
//   rdata = 0 and rbusy = 0 for every address.
//  Writes: registered, 1-cycle latency; visible on rdata the cycle after we is sampled.
//  Write conflict: two ports, same waddr, same cycle -> highest-index port's data stored.
//  ZERO_R0=1: writes to address 0 dropped, rdata for address 0 is 0, busy[0] stays 0
//   and alloc to address 0 is ignored.
//  Reads: purely combinational from the register array; no read latency.
//  Scoreboard, per register r, evaluated at each rising edge:
//   set   = alloc && alloc_rd==r;  clr = any we[k] && waddr[k]==r
//   set && clr -> busy stays 1 (the new producer wins over the retiring writer)
//   set only -> 1; clr only -> 0; neither -> hold
//  Repeated alloc of an already-busy register is legal; busy stays 1 (single bit,
//   not a counter; issue logic guarantees in-order write-back per rd).
//  Write to a non-busy register is legal: data stored, busy stays 0.
//  rbusy[i] = busy_vec[raddr[i]], registered state only (ignores same-cycle clr).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: rdata[i] returns the data of the highest-index port
//   with we[k] && waddr[k]==raddr[i] in the same cycle (ZERO_R0 exclusion still
//   applies); rbusy[i] is forced to 0 when such a match exists and no alloc of the
//   same register occurs in the same cycle.
//  Not defined: rdata/rbusy reflect registered state only; new data one cycle later.
// STRUCTURE
//  Package regfile_pkg: function addr_w(n) = $clog2(n); typedefs xword_t
//   (logic [XLEN-1:0]), reg_addr_t; constant REG_ZERO = '0.
//  Sub-module regfile_scoreboard: holds busy_vec, inputs alloc/alloc_rd plus the
//   write-port vectors, outputs busy_vec; rbusy muxing and bypass stay in regfile_mp.
//  Array and scoreboard are both reset in the same always_ff block style, async
//   negedge resetn.
// TESTING
//  1 Reset: drive writes, pulse resetn low mid-burst -> all rdata 0, busy_vec 0.
//  2 we[0]=1 waddr=5 wdata=0xDEAD_BEEF; next cycle raddr[0]=5 -> rdata[0]=0xDEADBEEF;
//   same-cycle read returns old 0 (or 0xDEADBEEF with REGFILE_BYPASS_EN).
//  3 we[0],we[1] both to reg 7, data 0x11 / 0x22 -> reg 7 reads 0x22.
//  4 ZERO_R0=1: write 0xFF to reg 0 and alloc 0 -> rdata=0, busy_vec[0]=0.
//  5 alloc 9 -> busy_vec[9]=1; later alloc 9 and we[1]/waddr 9 same cycle -> busy
//   stays 1; next write to 9 alone -> busy 0, data from that write.
//  6 Random multi-port traffic against a reference model, NRD=4 NWR=3 NREGS=16,
//   both macro settings -> zero mismatches over 10k cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 64;
  localparam int unsigned NREGS_DEF = 32;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef logic [XLEN_DEF-1:0]          xword_t;
  typedef logic [addr_w(NREGS_DEF)-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by allocation at issue, cleared by any write-back
// to the register; a same-cycle allocation wins over the retiring writer.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS   = 32,
  parameter int unsigned NWR     = 2,
  parameter int unsigned ZERO_R0 = 1,
  localparam int unsigned AW     = addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                alloc,
  input  logic [AW-1:0]       alloc_rd,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  output logic [NREGS-1:0]    busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] set_v;
  logic [NREGS-1:0] clr_v;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int r = 0; r < NREGS; r++) begin
      set_v[r] = alloc && (alloc_rd == AW'(r));
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && (waddr[k*AW +: AW] == AW'(r))) begin
          clr_v[r] = 1'b1;
        end
      end
    end
    busy_d = set_v | (busy_q & ~clr_v);
    // Hard-wired zero register never has a producer in flight.
    if (ZERO_R0 != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard.
// Optional same-cycle write->read bypass under macro REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned NRD     = 2,
  parameter int unsigned NWR     = 2,
  parameter int unsigned ZERO_R0 = 1,
  localparam int unsigned AW     = addr_w(NREGS)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR*XLEN-1:0]  wdata,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*XLEN-1:0]  rdata,
  output logic [NRD-1:0]       rbusy,
  input  logic                 alloc,
  input  logic [AW-1:0]        alloc_rd,
  output logic [NREGS-1:0]     busy_vec
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];

  function automatic logic is_r0(input logic [AW-1:0] a);
    return (ZERO_R0 != 0) && (a == AW'(REG_ZERO));
  endfunction

  // Ports are applied in ascending order so the highest index wins a conflict.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      mem_d[r] = mem_q[r];
    end
    for (int k = 0; k < NWR; k++) begin
      if (we[k] && !is_r0(waddr[k*AW +: AW])) begin
        mem_d[waddr[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= mem_d[r];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS   (NREGS),
    .NWR     (NWR),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk      (clk),
    .resetn   (resetn),
    .alloc    (alloc),
    .alloc_rd (alloc_rd),
    .we       (we),
    .waddr    (waddr),
    .busy_vec (busy_vec)
  );

`ifdef REGFILE_BYPASS_EN
  logic [NRD-1:0] byp_hit;
`endif

  always_comb begin
    rdata = '0;
    rbusy = '0;
`ifdef REGFILE_BYPASS_EN
    byp_hit = '0;
`endif
    for (int i = 0; i < NRD; i++) begin
      if (!is_r0(raddr[i*AW +: AW])) begin
        rdata[i*XLEN +: XLEN] = mem_q[raddr[i*AW +: AW]];
      end
      rbusy[i] = busy_vec[raddr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && (waddr[k*AW +: AW] == raddr[i*AW +: AW]) &&
            !is_r0(raddr[i*AW +: AW])) begin
          rdata[i*XLEN +: XLEN] = wdata[k*XLEN +: XLEN];
          byp_hit[i] = 1'b1;
        end
      end
      // A same-cycle allocation keeps the register busy even when bypassed.
      if (byp_hit[i] && !(alloc && (alloc_rd == raddr[i*AW +: AW]))) begin
        rbusy[i] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, reset corners and
// random multi-port traffic against a reference model.
module tb_regfile_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 16;
  localparam int NRD   = 4;
  localparam int NWR   = 3;
  localparam int AW    = 4;
  localparam int W     = XLEN*NRD + NRD + NREGS;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk;
  logic                resetn;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                alloc;
  logic [AW-1:0]       alloc_rd;
  logic [NREGS-1:0]    busy_vec;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_R0(1)
  ) dut (
    .clk(clk), .resetn(resetn), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .alloc(alloc),
    .alloc_rd(alloc_rd), .busy_vec(busy_vec)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  logic [XLEN-1:0]  m_mem [NREGS];
  logic [NREGS-1:0] m_busy;

  typedef struct {
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [AW-1:0]       ra;
    logic                alloc;
    logic [AW-1:0]       alloc_rd;
    logic [XLEN-1:0]     exp_rd;
    logic                exp_rb;
    logic [NREGS-1:0]    exp_bv;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] w, input logic [3:0] a0, a1, a2,
                              input logic [63:0] d0, d1, d2, input logic [3:0] ra,
                              input logic al, input logic [3:0] ard,
                              input logic [63:0] erd, input logic erb,
                              input logic [15:0] ebv);
    vec_t v;
    v.we = w; v.waddr = {a2, a1, a0}; v.wdata = {d2, d1, d0};
    v.ra = ra; v.alloc = al; v.alloc_rd = ard;
    v.exp_rd = erd; v.exp_rb = erb; v.exp_bv = ebv;
    return v;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
    m_busy = '0;
  endfunction

  // Expected outputs from model state plus the inputs currently driven.
  function automatic logic [W-1:0] model_exp();
    logic [NRD*XLEN-1:0] erd;
    logic [NRD-1:0]      erb;
    logic [AW-1:0]       a;
    bit                  hit;
    erd = '0;
    erb = '0;
    for (int i = 0; i < NRD; i++) begin
      a = raddr[i*AW +: AW];
      erd[i*XLEN +: XLEN] = (a == 0) ? '0 : m_mem[a];
      erb[i] = m_busy[a];
      if (BYP && a != 0) begin
        hit = 0;
        for (int k = NWR-1; k >= 0; k--) begin
          if (!hit && we[k] && waddr[k*AW +: AW] == a) begin
            erd[i*XLEN +: XLEN] = wdata[k*XLEN +: XLEN];
            hit = 1;
          end
        end
        if (hit && !(alloc && alloc_rd == a)) erb[i] = 1'b0;
      end
    end
    return {erd, erb, m_busy};
  endfunction

  function automatic void model_step();
    logic [NREGS-1:0] nb;
    bit               done;
    nb = m_busy;
    for (int r = 1; r < NREGS; r++) begin
      done = 0;
      for (int k = NWR-1; k >= 0; k--) begin
        if (we[k] && waddr[k*AW +: AW] == AW'(r)) begin
          if (!done) m_mem[r] = wdata[k*XLEN +: XLEN];
          done = 1;
        end
      end
      if (alloc && alloc_rd == AW'(r)) nb[r] = 1'b1;
      else if (done)                   nb[r] = 1'b0;
    end
    nb[0] = 1'b0;
    m_busy = nb;
  endfunction

  task automatic idle_inputs();
    we = '0; waddr = '0; wdata = '0; alloc = 1'b0; alloc_rd = '0;
  endtask

  task automatic check(input string name);
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard queue empty, got %h", name, {rdata, rbusy, busy_vec});
    end else begin
      exp_v = exp_q.pop_front();
      act_v = {rdata, rbusy, busy_vec};
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
      end
    end
  endtask

  task automatic drive_vec(input vec_t v);
    @(posedge clk); #1;
    we = v.we; waddr = v.waddr; wdata = v.wdata;
    raddr = {NRD{v.ra}}; alloc = v.alloc; alloc_rd = v.alloc_rd;
    exp_q.push_back({{NRD{v.exp_rd}}, {NRD{v.exp_rb}}, v.exp_bv});
    @(negedge clk);
    model_step();
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < NWR; k++) begin
      we[k] = ($urandom_range(0, 1) == 1);
      waddr[k*AW +: AW] = AW'($urandom_range(0, NREGS-1));
      wdata[k*XLEN +: XLEN] = {$urandom(), $urandom()};
    end
    for (int i = 0; i < NRD; i++) raddr[i*AW +: AW] = AW'($urandom_range(0, NREGS-1));
    alloc = ($urandom_range(0, 1) == 1);
    alloc_rd = AW'($urandom_range(0, NREGS-1));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    raddr = '0;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1 raddr = {4'd9, 4'd5, 4'd3, 4'd0};
    exp_q.push_back(model_exp());
    @(negedge clk);
    check("reset_state");
    resetn = 1'b1;

    // Reset asserted mid-burst of writes and allocations
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      rand_inputs();
      exp_q.push_back(model_exp());
      @(negedge clk);
      check("pre_reset_burst");
      model_step();
    end
    @(posedge clk); #3;
    resetn = 1'b0;
    model_clear();
    #1;
    idle_inputs();
    exp_q.push_back({{NRD*XLEN{1'b0}}, {NRD{1'b0}}, {NREGS{1'b0}}});
    #1 check("reset_async");
    @(negedge clk);
    resetn = 1'b1;
    for (int g = 0; g < NREGS/NRD; g++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NRD; i++) raddr[i*AW +: AW] = AW'(g*NRD + i);
      exp_q.push_back({{NRD*XLEN{1'b0}}, {NRD{1'b0}}, {NREGS{1'b0}}});
      @(negedge clk);
      check("post_reset_sweep");
    end

    // Directed vectors
    vecs.push_back(mk(3'b001, 4'd5, 4'd0, 4'd0, 64'hDEAD_BEEF, 0, 0, 4'd5, 0, 4'd0,
                      BYP ? 64'hDEAD_BEEF : 64'h0, 0, 16'h0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 4'd5, 0, 0, 64'hDEAD_BEEF, 0, 16'h0));
    vecs.push_back(mk(3'b011, 4'd7, 4'd7, 4'd0, 64'h11, 64'h22, 0, 4'd7, 0, 0,
                      BYP ? 64'h22 : 64'h0, 0, 16'h0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 4'd7, 0, 0, 64'h22, 0, 16'h0));
    vecs.push_back(mk(3'b001, 4'd0, 0, 0, 64'hFF, 0, 0, 4'd0, 1, 4'd0, 64'h0, 0, 16'h0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 64'h0, 0, 16'h0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 4'd9, 1, 4'd9, 64'h0, 0, 16'h0));
    vecs.push_back(mk(3'b010, 0, 4'd9, 0, 0, 64'h99, 0, 4'd9, 1, 4'd9,
                      BYP ? 64'h99 : 64'h0, 1, 16'h0200));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 4'd9, 0, 0, 64'h99, 1, 16'h0200));
    vecs.push_back(mk(3'b010, 0, 4'd9, 0, 0, 64'hAB, 0, 4'd9, 0, 0,
                      BYP ? 64'hAB : 64'h99, !BYP, 16'h0200));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 4'd9, 0, 0, 64'hAB, 0, 16'h0));
    vecs.push_back(mk(3'b100, 0, 0, 4'd3, 0, 0, 64'h33, 4'd12, 1, 4'd12, 64'h0, 0, 16'h0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 4'd3, 0, 0, 64'h33, 0, 16'h1000));
    for (int v = 0; v < vecs.size(); v++) begin
      @(posedge clk); #1;
      we = vecs[v].we; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
      raddr = {NRD{vecs[v].ra}}; alloc = vecs[v].alloc; alloc_rd = vecs[v].alloc_rd;
      exp_q.push_back({{NRD{vecs[v].exp_rd}}, {NRD{vecs[v].exp_rb}}, vecs[v].exp_bv});
      @(negedge clk);
      check($sformatf("vec%0d", v));
      model_step();
    end

    // Random multi-port traffic
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      rand_inputs();
      exp_q.push_back(model_exp());
      @(negedge clk);
      check("random");
      model_step();
    end

    @(posedge clk); #1;
    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, %0d checks made", checks);
    $fatal(1, "timeout");
  end

endmodule
